// File: rtl/serving_sched_pkg.sv
// Shared types and defaults for the serving RAM cycle scheduler.
package serving_sched_pkg;

  // WB transaction FSM: IDLE issues the access, IB/DB return the ack, ACK is the stb drop gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IB   = 2'd1,
    DB   = 2'd2,
    ACK  = 2'd3
  } state_t;

  // Owner of the single RAM port in the current cycle.
  typedef enum logic [2:0] {
    G_NONE = 3'd0,
    G_RF   = 3'd1,
    G_IB   = 3'd2,
    G_DB   = 3'd3,
    G_WBUF = 3'd4
  } grant_t;

  localparam int AW_DEF          = 11;
  localparam int WB_MAX_WAIT_DEF = 8;

  // One-hot byte write enable for an RF byte landing in a 32-bit word.
  function automatic logic [3:0] lane_we(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/serving_sched_wbuf.sv
// One-entry RF byte write buffer with read-address forward compare.
module serving_sched_wbuf
  import serving_sched_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          park,
  input  logic [AW+1:0] park_addr,
  input  logic [7:0]    park_data,
  input  logic          drain,
  input  logic [AW+1:0] raddr,
  output logic          full,
  output logic          hit,
  output logic [AW+1:0] buf_addr,
  output logic [7:0]    buf_data
);

  // Park a write when the scheduler defers it; free the slot when it reaches the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (park) begin
      full     <= 1'b1;
      buf_addr <= park_addr;
      buf_data <= park_data;
    end else if (drain) begin
      full     <= 1'b0;
    end
  end

  assign hit = full && (raddr == buf_addr);

endmodule

// File: rtl/serving_ram_sched.sv
// Cycle scheduler for the shared single-port RAM (code/data plus RF).
// Priority each cycle: forced WB grant > RF access > round-robin ibus/dbus.
// Optional one-entry RF write buffer: define SERVING_SCHED_WBUF_EN.
//
// Handshakes: the RF side holds wen/ren and addresses until o_rf_ready is
// high in the same cycle; read data follows with o_rf_rvalid one cycle
// after acceptance. Wishbone masters hold stb until their ack pulse; ack is
// a single cycle and the following cycle is never regranted, so a master
// can drop stb without being served twice.
module serving_ram_sched
  import serving_sched_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int WB_MAX_WAIT = WB_MAX_WAIT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rf_wen,
  input  logic [AW+1:0] i_rf_waddr,
  input  logic [7:0]    i_rf_wdata,
  input  logic          i_rf_ren,
  input  logic [AW+1:0] i_rf_raddr,
  output logic          o_rf_ready,
  output logic [7:0]    o_rf_rdata,
  output logic          o_rf_rvalid,
  input  logic [31:0]   i_ib_adr,
  input  logic          i_ib_stb,
  output logic [31:0]   o_ib_rdt,
  output logic          o_ib_ack,
  input  logic [31:0]   i_db_adr,
  input  logic [31:0]   i_db_dat,
  input  logic [3:0]    i_db_sel,
  input  logic          i_db_we,
  input  logic          i_db_stb,
  output logic [31:0]   o_db_rdt,
  output logic          o_db_ack,
  output logic          o_ram_en,
  output logic [AW-1:0] o_ram_addr,
  output logic [3:0]    o_ram_we,
  output logic [31:0]   o_ram_wdata,
  input  logic [31:0]   i_ram_rdata,
  output logic [1:0]    o_dbg_state
);

  localparam int            CW       = $clog2(WB_MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(WB_MAX_WAIT);

  state_t        state;
  grant_t        grant;
  logic          rr_last_ib;
  logic [CW-1:0] wait_cnt;
  logic          ib_ack_q;
  logic          db_ack_q;
  logic          rvalid_q;
  logic [1:0]    rsel_q;
  logic          wb_pend;
  logic          forced;
  logic          pick_db;
  logic          rf_rd_go;
  logic          rf_wr_go;
  logic          rf_ready;
  logic [7:0]    rf_byte;

`ifdef SERVING_SCHED_WBUF_EN
  logic          park;
  logic          drain;
  logic          wbuf_full;
  logic          wbuf_hit;
  logic [AW+1:0] wbuf_addr;
  logic [7:0]    wbuf_data;
  logic          fwd_q;
  logic [7:0]    fwd_byte_q;

  assign drain = (grant == G_WBUF);

  serving_sched_wbuf #(.AW(AW)) u_wbuf (
    .clk       (i_clk),
    .rst       (i_rst),
    .park      (park),
    .park_addr (i_rf_waddr),
    .park_data (i_rf_wdata),
    .drain     (drain),
    .raddr     (i_rf_raddr),
    .full      (wbuf_full),
    .hit       (wbuf_hit),
    .buf_addr  (wbuf_addr),
    .buf_data  (wbuf_data)
  );
`else
  // Set once the write half of a read+write pair has reached the RAM.
  logic          wr_done;
`endif

  // Decide who owns the RAM port this cycle.
  always_comb begin
    grant    = G_NONE;
    rf_rd_go = 1'b0;
    rf_wr_go = 1'b0;
    rf_ready = 1'b0;
`ifdef SERVING_SCHED_WBUF_EN
    park     = 1'b0;
`endif
    wb_pend  = (state == IDLE) && (i_ib_stb || i_db_stb);
    forced   = wb_pend && (wait_cnt == WAIT_SAT);
    // dbus wins when it is alone or when ibus was served last.
    pick_db  = i_db_stb && (!i_ib_stb || rr_last_ib);
    if (i_rst) begin
      grant = G_NONE;
    end else if (forced) begin
      grant = pick_db ? G_DB : G_IB;
    end else begin
`ifdef SERVING_SCHED_WBUF_EN
      if (i_rf_ren && (!i_rf_wen || !wbuf_full)) begin
        // Read goes to RAM; a simultaneous write is parked.
        grant    = G_RF;
        rf_rd_go = 1'b1;
        rf_ready = 1'b1;
        park     = i_rf_wen;
      end else if (i_rf_wen && !wbuf_full) begin
        grant    = G_RF;
        rf_wr_go = 1'b1;
        rf_ready = 1'b1;
      end else if (wbuf_full) begin
        // Buffer must empty before any round-robin WB grant.
        grant    = G_WBUF;
      end else if (wb_pend) begin
        grant    = pick_db ? G_DB : G_IB;
      end
`else
      if (i_rf_wen && i_rf_ren && !wr_done) begin
        // Write first; the read is held and accepted next cycle.
        grant    = G_RF;
        rf_wr_go = 1'b1;
      end else if (i_rf_ren) begin
        grant    = G_RF;
        rf_rd_go = 1'b1;
        rf_ready = 1'b1;
      end else if (i_rf_wen) begin
        grant    = G_RF;
        rf_wr_go = 1'b1;
        rf_ready = 1'b1;
      end else if (wb_pend) begin
        grant    = pick_db ? G_DB : G_IB;
      end
`endif
    end
  end

  // Drive the RAM port from the selected requester.
  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_addr  = '0;
    o_ram_we    = '0;
    o_ram_wdata = '0;
    case (grant)
      G_RF: begin
        o_ram_en = 1'b1;
        if (rf_rd_go) begin
          o_ram_addr = i_rf_raddr[AW+1:2];
        end else begin
          o_ram_addr  = i_rf_waddr[AW+1:2];
          o_ram_we    = lane_we(i_rf_waddr[1:0]);
          o_ram_wdata = {4{i_rf_wdata}};
        end
      end
      G_IB: begin
        o_ram_en   = 1'b1;
        o_ram_addr = i_ib_adr[AW+1:2];
      end
      G_DB: begin
        o_ram_en    = 1'b1;
        o_ram_addr  = i_db_adr[AW+1:2];
        o_ram_we    = i_db_we ? i_db_sel : 4'b0000;
        o_ram_wdata = i_db_dat;
      end
`ifdef SERVING_SCHED_WBUF_EN
      G_WBUF: begin
        o_ram_en    = 1'b1;
        o_ram_addr  = wbuf_addr[AW+1:2];
        o_ram_we    = lane_we(wbuf_addr[1:0]);
        o_ram_wdata = {4{wbuf_data}};
      end
`endif
      default: ;
    endcase
  end

  // WB transaction FSM, round-robin pointer, starvation counter and RF read pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      rr_last_ib <= 1'b1;
      wait_cnt   <= '0;
      ib_ack_q   <= 1'b0;
      db_ack_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rsel_q     <= '0;
`ifdef SERVING_SCHED_WBUF_EN
      fwd_q      <= 1'b0;
      fwd_byte_q <= '0;
`else
      wr_done    <= 1'b0;
`endif
    end else begin
      ib_ack_q <= (grant == G_IB);
      db_ack_q <= (grant == G_DB);
      case (state)
        IDLE: begin
          if (grant == G_IB)      state <= IB;
          else if (grant == G_DB) state <= DB;
        end
        IB, DB:  state <= ACK;
        default: state <= IDLE;
      endcase
      if (grant == G_IB)      rr_last_ib <= 1'b1;
      else if (grant == G_DB) rr_last_ib <= 1'b0;
      // A dropped stb leaves nothing waiting, so the count restarts.
      if (grant == G_IB || grant == G_DB) begin
        wait_cnt <= '0;
      end else if (wb_pend) begin
        if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
      end else if (state == IDLE) begin
        wait_cnt <= '0;
      end
      rvalid_q <= rf_rd_go;
      if (rf_rd_go) rsel_q <= i_rf_raddr[1:0];
`ifdef SERVING_SCHED_WBUF_EN
      if (rf_rd_go) begin
        fwd_q      <= wbuf_hit;
        fwd_byte_q <= wbuf_data;
      end
`else
      if (rf_ready)                   wr_done <= 1'b0;
      else if (rf_wr_go && i_rf_ren)  wr_done <= 1'b1;
`endif
    end
  end

  // Select the byte lane of the returned word (or the forwarded buffered byte).
  always_comb begin
    case (rsel_q)
      2'd0:    rf_byte = i_ram_rdata[7:0];
      2'd1:    rf_byte = i_ram_rdata[15:8];
      2'd2:    rf_byte = i_ram_rdata[23:16];
      default: rf_byte = i_ram_rdata[31:24];
    endcase
`ifdef SERVING_SCHED_WBUF_EN
    if (fwd_q) rf_byte = fwd_byte_q;
`endif
  end

  assign o_rf_ready  = rf_ready;
  assign o_rf_rvalid = rvalid_q;
  assign o_rf_rdata  = rvalid_q ? rf_byte : 8'h00;
  // Acks are masked during reset so an in-flight transaction is abandoned silently.
  assign o_ib_ack    = ib_ack_q & ~i_rst;
  assign o_db_ack    = db_ack_q & ~i_rst;
  assign o_ib_rdt    = o_ib_ack ? i_ram_rdata : 32'h0;
  assign o_db_rdt    = o_db_ack ? i_ram_rdata : 32'h0;
  assign o_dbg_state = state;

  // Only the word-address bits of the WB addresses select RAM words.
  logic unused_adr;
  assign unused_adr = ^{i_ib_adr[31:AW+2], i_ib_adr[1:0], i_db_adr[31:AW+2], i_db_adr[1:0]};

endmodule

// File: tb/tb_serving_ram_sched.sv
// Directed bench for serving_ram_sched with a 1-cycle-latency RAM model.
module tb_serving_ram_sched;

  localparam int AW = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          rf_wen, rf_ren, rf_ready, rf_rvalid;
  logic [AW+1:0] rf_waddr, rf_raddr;
  logic [7:0]    rf_wdata, rf_rdata;
  logic [31:0]   ib_adr, ib_rdt, db_adr, db_dat, db_rdt;
  logic          ib_stb, ib_ack, db_we, db_stb, db_ack;
  logic [3:0]    db_sel, ram_we;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [1:0]    dbg_state;

  serving_ram_sched #(.AW(AW), .WB_MAX_WAIT(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rf_wen(rf_wen), .i_rf_waddr(rf_waddr), .i_rf_wdata(rf_wdata),
    .i_rf_ren(rf_ren), .i_rf_raddr(rf_raddr),
    .o_rf_ready(rf_ready), .o_rf_rdata(rf_rdata), .o_rf_rvalid(rf_rvalid),
    .i_ib_adr(ib_adr), .i_ib_stb(ib_stb), .o_ib_rdt(ib_rdt), .o_ib_ack(ib_ack),
    .i_db_adr(db_adr), .i_db_dat(db_dat), .i_db_sel(db_sel), .i_db_we(db_we),
    .i_db_stb(db_stb), .o_db_rdt(db_rdt), .o_db_ack(db_ack),
    .o_ram_en(ram_en), .o_ram_addr(ram_addr), .o_ram_we(ram_we),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_dbg_state(dbg_state)
  );

  // RAM model: read-before-write, 1-cycle read latency, preloaded during reset.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
      mem[11'h7FD] <= 32'hA1B2C3D4;
      mem[11'h004] <= 32'hCAFEF00D;
      ram_rdata    <= 32'h0;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf_byte(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed %h expected <nothing queued>", tag, rf_rdata);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'h0, rf_rdata}, {24'h0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    rf_wen = 1'b0; rf_waddr = '0; rf_wdata = '0; rf_ren = 1'b0; rf_raddr = '0;
    ib_adr = '0; ib_stb = 1'b0;
    db_adr = '0; db_dat = '0; db_sel = '0; db_we = 1'b0; db_stb = 1'b0;
  endtask

  task automatic drive_rf(input logic wen, input logic [AW+1:0] waddr, input logic [7:0] wdata,
                          input logic ren, input logic [AW+1:0] raddr);
    rf_wen = wen; rf_waddr = waddr; rf_wdata = wdata; rf_ren = ren; rf_raddr = raddr;
  endtask

  task automatic drive_db(input logic stb, input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] dat);
    db_stb = stb; db_we = we; db_adr = adr; db_sel = sel; db_dat = dat;
  endtask

  // Watchdog: the directed sequence is short, so this only fires on a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) nxt();
    #1;
    chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
    chk("rst_rf_ready", {31'h0, rf_ready}, 32'h0);
    chk("rst_rf_rvalid", {31'h0, rf_rvalid}, 32'h0);
    chk("rst_acks", {30'h0, ib_ack, db_ack}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    nxt(); rst = 1'b0;

    // RF read: byte 0x1FF6 -> word 0x7FD, lane 2
    nxt(); drive_rf(1'b0, '0, '0, 1'b1, 13'h1FF6); #1;
    chk("rf_rd_ready", {31'h0, rf_ready}, 32'h1);
    chk("rf_rd_addr", {21'h0, ram_addr}, 32'h7FD);
    chk("rf_rd_we", {28'h0, ram_we}, 32'h0);
    exp_q.push_back(8'hB2);
    nxt(); drive_rf(1'b0, '0, '0, 1'b0, '0); #1;
    chk("rf_rd_rvalid", {31'h0, rf_rvalid}, 32'h1);
    chk_rf_byte("rf_rd_byte");

    // ibus + dbus together, pointer at ibus: dbus first, gap, then ibus
    nxt(); ib_stb = 1'b1; ib_adr = 32'h0000_1FF4;
    drive_db(1'b1, 1'b0, 32'hFFFF_0010, 4'hF, 32'h0); #1;
    chk("rr_db_addr", {21'h0, ram_addr}, 32'h4);
    chk("rr_db_en", {31'h0, ram_en}, 32'h1);
    nxt(); #1;
    chk("rr_db_ack", {30'h0, ib_ack, db_ack}, 32'h1);
    chk("rr_db_rdt", db_rdt, 32'hCAFEF00D);
    chk("rr_db_state", {30'h0, dbg_state}, 32'h2);
    chk("rr_busy_no_ram", {31'h0, ram_en}, 32'h0);
    nxt(); db_stb = 1'b0; #1;
    chk("rr_gap_state", {30'h0, dbg_state}, 32'h3);
    chk("rr_gap_no_grant", {31'h0, ram_en}, 32'h0);
    nxt(); #1;
    chk("rr_ib_en", {31'h0, ram_en}, 32'h1);
    chk("rr_ib_addr", {21'h0, ram_addr}, 32'h7FD);
    nxt(); #1;
    chk("rr_ib_ack", {30'h0, ib_ack, db_ack}, 32'h2);
    chk("rr_ib_rdt", ib_rdt, 32'hA1B2C3D4);
    nxt(); ib_stb = 1'b0; #1;

    // dbus partial write then readback
    nxt(); drive_db(1'b1, 1'b1, 32'h0000_0010, 4'h3, 32'h12345678); #1;
    chk("db_wr_we", {28'h0, ram_we}, 32'h3);
    chk("db_wr_addr", {21'h0, ram_addr}, 32'h4);
    chk("db_wr_wdata", ram_wdata, 32'h12345678);
    nxt(); #1;
    chk("db_wr_ack", {31'h0, db_ack}, 32'h1);
    nxt(); drive_db(1'b0, 1'b0, 32'h10, 4'hF, 32'h0); #1;
    nxt(); db_stb = 1'b1; #1;
    chk("db_rd_we", {28'h0, ram_we}, 32'h0);
    nxt(); #1;
    chk("db_rd_ack", {31'h0, db_ack}, 32'h1);
    chk("db_rd_rdt", db_rdt, 32'hCAFE5678);
    nxt(); db_stb = 1'b0; #1;
    nxt(); #1;
    chk("quiet_ram_en", {31'h0, ram_en}, 32'h0);

    // Continuous RF reads starve ibus until the wait counter saturates
    nxt(); drive_rf(1'b0, '0, '0, 1'b1, 13'h0000); ib_stb = 1'b1; ib_adr = 32'h0000_1FF4;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) nxt();
      #1;
      chk($sformatf("starve_ready_c%0d", k), {31'h0, rf_ready}, (k == 8) ? 32'h0 : 32'h1);
      chk($sformatf("starve_addr_c%0d", k), {21'h0, ram_addr}, (k == 8) ? 32'h7FD : 32'h0);
    end
    nxt(); #1;
    chk("forced_ib_ack", {31'h0, ib_ack}, 32'h1);
    chk("forced_rf_back", {31'h0, rf_ready}, 32'h1);
    chk("forced_no_rvalid", {31'h0, rf_rvalid}, 32'h0);
    nxt(); ib_stb = 1'b0; rf_ren = 1'b0; #1;
    nxt(); #1;

    // RF read + write in the same cycle
    nxt(); drive_rf(1'b1, 13'h1F00, 8'h5A, 1'b1, 13'h1FF6); #1;
`ifdef SERVING_SCHED_WBUF_EN
    chk("rw_ready_both", {31'h0, rf_ready}, 32'h1);
    chk("rw_read_addr", {21'h0, ram_addr}, 32'h7FD);
    chk("rw_read_we", {28'h0, ram_we}, 32'h0);
    exp_q.push_back(8'hB2);
    nxt(); drive_rf(1'b0, '0, '0, 1'b0, '0); #1;
    chk("rw_rvalid", {31'h0, rf_rvalid}, 32'h1);
    chk_rf_byte("rw_rbyte");
    chk("rw_drain_we", {28'h0, ram_we}, 32'h1);
    chk("rw_drain_addr", {21'h0, ram_addr}, 32'h7C0);
    chk("rw_drain_wdata", ram_wdata, 32'h5A5A5A5A);

    // Read of a still-buffered byte is forwarded
    nxt(); drive_rf(1'b1, 13'h1F00, 8'hC3, 1'b1, 13'h1FF6); #1;
    chk("fw_ready_park", {31'h0, rf_ready}, 32'h1);
    exp_q.push_back(8'hB2);
    nxt(); drive_rf(1'b0, '0, '0, 1'b1, 13'h1F00); #1;
    chk("fw_ready_read", {31'h0, rf_ready}, 32'h1);
    chk("fw_no_drain", {28'h0, ram_we}, 32'h0);
    chk_rf_byte("fw_first_byte");
    exp_q.push_back(8'hC3);
    nxt(); drive_rf(1'b0, '0, '0, 1'b0, '0); #1;
    chk("fw_rvalid", {31'h0, rf_rvalid}, 32'h1);
    chk_rf_byte("fw_fwd_byte");
    chk("fw_drain_wdata", ram_wdata, 32'hC3C3C3C3);
`else
    chk("rw_ready_held", {31'h0, rf_ready}, 32'h0);
    chk("rw_write_we", {28'h0, ram_we}, 32'h1);
    chk("rw_write_addr", {21'h0, ram_addr}, 32'h7C0);
    chk("rw_write_wdata", ram_wdata, 32'h5A5A5A5A);
    nxt(); #1;
    chk("rw_ready_read", {31'h0, rf_ready}, 32'h1);
    chk("rw_read_addr", {21'h0, ram_addr}, 32'h7FD);
    chk("rw_read_we", {28'h0, ram_we}, 32'h0);
    exp_q.push_back(8'hB2);
    nxt(); drive_rf(1'b0, '0, '0, 1'b0, '0); #1;
    chk("rw_rvalid", {31'h0, rf_rvalid}, 32'h1);
    chk_rf_byte("rw_rbyte");
    // Written byte reads back through the RAM
    nxt(); drive_rf(1'b0, '0, '0, 1'b1, 13'h1F00); #1;
    exp_q.push_back(8'h5A);
    nxt(); drive_rf(1'b0, '0, '0, 1'b0, '0); #1;
    chk_rf_byte("rw_readback");
`endif

    // dbus stb dropped before it is granted: no access, no ack
    nxt(); drive_rf(1'b0, '0, '0, 1'b1, 13'h0000); drive_db(1'b1, 1'b0, 32'h10, 4'hF, 32'h0); #1;
    chk("drop_rf_wins", {31'h0, rf_ready}, 32'h1);
    nxt(); db_stb = 1'b0; #1;
    nxt(); rf_ren = 1'b0; #1;
    chk("drop_no_ram", {31'h0, ram_en}, 32'h0);
    chk("drop_no_ack", {31'h0, db_ack}, 32'h0);
    nxt(); #1;
    chk("drop_no_ack_late", {31'h0, db_ack}, 32'h0);

    // Reset while the ack is due: ack suppressed, FSM back to IDLE
    nxt(); drive_db(1'b1, 1'b0, 32'h10, 4'hF, 32'h0); #1;
    chk("rstmid_grant", {31'h0, ram_en}, 32'h1);
    nxt(); rst = 1'b1; #1;
    chk("rstmid_no_ack", {31'h0, db_ack}, 32'h0);
    chk("rstmid_no_rdt", db_rdt, 32'h0);
    nxt(); rst = 1'b0; db_stb = 1'b0; #1;
    chk("rstmid_idle", {30'h0, dbg_state}, 32'h0);
    chk("rstmid_ack_low", {31'h0, db_ack}, 32'h0);
    nxt(); db_stb = 1'b1; #1;
    chk("post_rst_grant", {31'h0, ram_en}, 32'h1);
    nxt(); #1;
    chk("post_rst_ack", {31'h0, db_ack}, 32'h1);
    chk("post_rst_rdt", db_rdt, 32'hCAFEF00D);
    nxt(); db_stb = 1'b0; #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
